// File: rtl/countdown_sequencer.sv
// BCD MM:SS countdown sequencer; COUNTDOWN_AUTO_RELOAD_EN reloads the last legal value on expiry.
// Latency: a qualified tick or strobe sampled at posedge N is visible on the outputs after posedge N.
// Backpressure: none; the strobes are one cycle wide, and timer_en gates the tick source outside RUN.
module countdown_sequencer #(
    parameter int MIN_TENS_MAX     = 9,
    parameter int TICK_WIDTH_CHECK = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        start,
    input  logic        pause,
    input  logic        clear,
    output logic        timer_en,
    output logic [15:0] digits,
    output logic        running,
    output logic        expired,
    output logic        load_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOADED,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] digits_q, digits_nxt;
    logic        expired_q, expired_nxt;
    logic        load_err_q, load_err_nxt;
    logic        tick_q;
    logic        tick_qual;
    logic        load_ok;
    logic        start_ok;
    logic [15:0] dec_val;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [15:0] shadow_q, shadow_nxt;
`endif

    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [3:0] mt, mo, st, so;
        {mt, mo, st, so} = v;
        if (so != 4'd0) begin
            so = so - 4'd1;
        end else begin
            so = 4'd9;
            if (st != 4'd0) begin
                st = st - 4'd1;
            end else begin
                st = 4'd5;
                if (mo != 4'd0) begin
                    mo = mo - 4'd1;
                end else begin
                    mo = 4'd9;
                    mt = mt - 4'd1;
                end
            end
        end
        return {mt, mo, st, so};
    endfunction

    // With width checking, a tick held high counts only on its first cycle.
    assign tick_qual = (TICK_WIDTH_CHECK != 0) ? (tick & ~tick_q) : tick;
    assign dec_val   = bcd_dec(digits_q);
    assign load_ok   = (int'(load_val[15:12]) <= MIN_TENS_MAX) && (load_val[15:12] <= 4'd9) &&
                       (load_val[11:8] <= 4'd9) && (load_val[7:4] <= 4'd5) && (load_val[3:0] <= 4'd9);
    assign start_ok  = start && ((state == S_LOADED) || (state == S_PAUSE)) && (digits_q != 16'h0000);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            digits_q   <= 16'h0000;
            expired_q  <= 1'b0;
            load_err_q <= 1'b0;
            tick_q     <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            shadow_q   <= 16'h0000;
`endif
        end else begin
            state      <= state_nxt;
            digits_q   <= digits_nxt;
            expired_q  <= expired_nxt;
            load_err_q <= load_err_nxt;
            tick_q     <= tick;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            shadow_q   <= shadow_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt    = state;
        digits_nxt   = digits_q;
        expired_nxt  = 1'b0;
        load_err_nxt = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        shadow_nxt   = shadow_q;
`endif
        if (clear) begin
            state_nxt  = S_IDLE;
            digits_nxt = 16'h0000;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            shadow_nxt = 16'h0000;
`endif
        end else if (state == S_RUN) begin
            // A tick coinciding with pause is still applied; expiry outranks the pause.
            if (tick_qual) begin
                digits_nxt = dec_val;
            end
            if (pause) begin
                state_nxt = S_PAUSE;
            end
            if (tick_qual && (dec_val == 16'h0000)) begin
                expired_nxt = 1'b1;
                state_nxt   = S_DONE;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                if (shadow_q != 16'h0000) begin
                    digits_nxt = shadow_q;
                    state_nxt  = pause ? S_PAUSE : S_RUN;
                end
`endif
            end
        end else if (!pause) begin
            if (start_ok) begin
                state_nxt = S_RUN;
            end else if (load) begin
                if (load_ok) begin
                    state_nxt  = S_LOADED;
                    digits_nxt = load_val;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    shadow_nxt = load_val;
`endif
                end else begin
                    load_err_nxt = 1'b1;
                end
            end
        end
    end

    assign timer_en = (state == S_RUN);
    assign running  = (state == S_RUN);
    assign digits   = digits_q;
    assign expired  = expired_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Drives two sequencers (tick width check on and off) with shared stimulus and compares both against a seconds-based model.
module tb_countdown_sequencer;

    logic        clk = 1'b0;
    logic        rst, tick, load, start, pause, clear;
    logic [15:0] load_val;

    logic        te1, rn1, ex1, le1;
    logic [15:0] dg1;
    logic        te0, rn0, ex0, le0;
    logic [15:0] dg0;

    int errors = 0;
    int checks = 0;

    localparam int M_IDLE = 0, M_LOADED = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    int m_st[2];
    int m_secs[2];
    int m_shadow[2];
    bit m_exp[2];
    bit m_err[2];
    bit m_prev[2];

    countdown_sequencer #(.MIN_TENS_MAX(9), .TICK_WIDTH_CHECK(1)) dut (
        .clk(clk), .rst(rst), .tick(tick), .load(load), .load_val(load_val),
        .start(start), .pause(pause), .clear(clear),
        .timer_en(te1), .digits(dg1), .running(rn1), .expired(ex1), .load_err(le1)
    );

    countdown_sequencer #(.MIN_TENS_MAX(9), .TICK_WIDTH_CHECK(0)) dut0 (
        .clk(clk), .rst(rst), .tick(tick), .load(load), .load_val(load_val),
        .start(start), .pause(pause), .clear(clear),
        .timer_en(te0), .digits(dg0), .running(rn0), .expired(ex0), .load_err(le0)
    );

    always #5 clk = ~clk;

    function automatic int to_secs(input logic [15:0] v);
        return (int'(v[15:12]) * 10 + int'(v[11:8])) * 60 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [15:0] to_bcd(input int s);
        int m, r;
        m = s / 60;
        r = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(r / 10), 4'(r % 10)};
    endfunction

    function automatic bit legal(input logic [15:0] v);
        return (v[15:12] <= 4'd9) && (v[11:8] <= 4'd9) && (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
    endfunction

    task automatic model_step(input int k, input bit twc);
        bit qt;
        if (!rst) begin
            m_st[k] = M_IDLE; m_secs[k] = 0; m_shadow[k] = 0;
            m_exp[k] = 0; m_err[k] = 0; m_prev[k] = 0;
            return;
        end
        qt = tick && (!twc || !m_prev[k]);
        m_prev[k] = tick;
        m_exp[k] = 0;
        m_err[k] = 0;
        if (clear) begin
            m_st[k] = M_IDLE; m_secs[k] = 0; m_shadow[k] = 0;
        end else if (m_st[k] == M_RUN) begin
            if (qt) m_secs[k] = m_secs[k] - 1;
            if (pause) m_st[k] = M_PAUSE;
            if (qt && m_secs[k] == 0) begin
                m_exp[k] = 1;
                if (AUTO && m_shadow[k] != 0) begin
                    m_secs[k] = m_shadow[k];
                    m_st[k] = pause ? M_PAUSE : M_RUN;
                end else begin
                    m_st[k] = M_DONE;
                end
            end
        end else if (!pause) begin
            if (start && (m_st[k] == M_LOADED || m_st[k] == M_PAUSE) && m_secs[k] != 0) begin
                m_st[k] = M_RUN;
            end else if (load) begin
                if (legal(load_val)) begin
                    m_st[k] = M_LOADED;
                    m_secs[k] = to_secs(load_val);
                    m_shadow[k] = to_secs(load_val);
                end else begin
                    m_err[k] = 1;
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step(0, 1'b1);
        model_step(1, 1'b0);
        #1;
        check("digits_w1",   dg1, to_bcd(m_secs[0]));
        check("running_w1",  16'(rn1), 16'(m_st[0] == M_RUN));
        check("timer_en_w1", 16'(te1), 16'(m_st[0] == M_RUN));
        check("expired_w1",  16'(ex1), 16'(m_exp[0]));
        check("load_err_w1", 16'(le1), 16'(m_err[0]));
        check("digits_w0",   dg0, to_bcd(m_secs[1]));
        check("running_w0",  16'(rn0), 16'(m_st[1] == M_RUN));
        check("timer_en_w0", 16'(te0), 16'(m_st[1] == M_RUN));
        check("expired_w0",  16'(ex0), 16'(m_exp[1]));
        check("load_err_w0", 16'(le0), 16'(m_err[1]));
    endtask

    task automatic pulse_load(input logic [15:0] v);
        load = 1'b1; load_val = v; step(); load = 1'b0;
    endtask
    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask
    task automatic pulse_pause();
        pause = 1'b1; step(); pause = 1'b0;
    endtask
    task automatic pulse_clear();
        clear = 1'b1; step(); clear = 1'b0;
    endtask
    task automatic pulse_tick();
        tick = 1'b1; step(); tick = 1'b0;
    endtask
    task automatic idle(input int n);
        repeat (n) step();
    endtask

    initial begin
        rst = 1'b0; tick = 1'b0; load = 1'b0; start = 1'b0;
        pause = 1'b0; clear = 1'b0; load_val = 16'h0000;

        // Reset state
        idle(2);
        check("rst_digits", dg1, 16'h0000);
        check("rst_timer_en", 16'(te1), 16'h0);
        check("rst_running", 16'(rn1), 16'h0);
        check("rst_expired", 16'(ex1), 16'h0);
        check("rst_load_err", 16'(le1), 16'h0);
        rst = 1'b1;
        idle(1);

        // 00:03 countdown to expiry
        pulse_load(16'h0003);
        pulse_start();
        check("run_after_start", 16'(rn1), 16'h1);
        for (int i = 0; i < 3; i++) begin
            pulse_tick();
            check("count3_digits", dg1, 16'(2 - i));
            if (i == 2) begin
                check("expiry_pulse", 16'(ex1), 16'h1);
                check("expiry_timer_en", 16'(te1), 16'h0);
            end
            idle(4);
        end
        check("expired_cleared", 16'(ex1), 16'h0);
        pulse_start();
        check("done_ignores_start", 16'(rn1), 16'h0);

        // Borrow chains
        pulse_load(16'h1000);
        pulse_start();
        pulse_tick();
        check("borrow_1000", dg1, 16'h0959);
        pulse_pause();
        pulse_load(16'h0100);
        pulse_start();
        idle(1);
        pulse_tick();
        check("borrow_0100", dg1, 16'h0059);

        // Illegal loads
        pulse_clear();
        pulse_load(16'h0012);
        pulse_load(16'h0070);
        check("err_sec_tens", 16'(le1), 16'h1);
        check("err_sec_tens_digits", dg1, 16'h0012);
        idle(1);
        check("err_one_cycle", 16'(le1), 16'h0);
        pulse_load(16'hA000);
        check("err_min_tens", 16'(le1), 16'h1);
        check("err_min_tens_digits", dg1, 16'h0012);
        pulse_start();
        check("loaded_kept_start", 16'(rn1), 16'h1);
        pulse_clear();
        pulse_load(16'h0000);
        pulse_start();
        check("zero_start_ignored", 16'(rn1), 16'h0);

        // Pause with a simultaneous tick
        pulse_load(16'h0005);
        pulse_start();
        pulse_tick(); idle(1);
        pulse_tick(); idle(1);
        tick = 1'b1; pause = 1'b1; step(); tick = 1'b0; pause = 1'b0;
        check("pause_tick_digits", dg1, 16'h0002);
        check("pause_timer_en", 16'(te1), 16'h0);
        idle(1); pulse_tick(); idle(1);
        check("pause_ignores_tick", dg1, 16'h0002);
        pulse_start(); idle(1);
        pulse_tick();
        check("resume_tick", dg1, 16'h0001);

        // Held tick: one count with width check, four without
        pulse_clear();
        pulse_load(16'h0010);
        pulse_start();
        tick = 1'b1; idle(4); tick = 1'b0;
        check("held_tick_w1", dg1, 16'h0009);
        check("held_tick_w0", dg0, 16'h0006);

        // Reset mid-run
        pulse_clear();
        pulse_load(16'h0042);
        pulse_start();
        idle(2);
        rst = 1'b0; step(); rst = 1'b1;
        check("midrst_digits", dg1, 16'h0000);
        check("midrst_running", 16'(rn1), 16'h0);
        check("midrst_timer_en", 16'(te1), 16'h0);
        idle(1);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
        pulse_load(16'h0002);
        pulse_start();
        pulse_tick(); idle(1);
        pulse_tick();
        check("auto_expired", 16'(ex1), 16'h1);
        check("auto_digits", dg1, 16'h0002);
        check("auto_running", 16'(rn1), 16'h1);
        pulse_clear();
`endif

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst   = ($urandom_range(0, 299) != 0);
            clear = ($urandom_range(0, 59) == 0);
            pause = ($urandom_range(0, 11) == 0);
            start = ($urandom_range(0, 5) == 0);
            load  = ($urandom_range(0, 9) == 0);
            tick  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) != 0)
                load_val = {4'd0, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
            else
                load_val = 16'($urandom);
            step();
        end
        rst = 1'b1; clear = 1'b0; pause = 1'b0; start = 1'b0; load = 1'b0; tick = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/countdown_sequencer.md
Name: countdown_sequencer

Overview:
- Consumer end of the one-second tick interface.
- Drives `timer_en` to the seconds-tick generator and receives its 1-cycle `tick` pulse.
- Holds a BCD MM:SS value, loads it, and counts it down one second per tick.
- Flags expiry. Sits between the user-control debouncers and the 7-segment display drivers of the lab timer design.

Parameters:
- MIN_TENS_MAX, 9, largest legal minutes-tens digit accepted on load (range 0-9).
- TICK_WIDTH_CHECK, 1, when 1 a `tick` held high for more than one consecutive cycle counts only once (rising-edge qualify); when 0 every high cycle counts.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-low reset
- tick  input  1  one-second pulse from the tick generator; meaningful only while `timer_en`=1
- load  input  1  1-cycle strobe: capture `load_val`
- load_val  input  16  BCD {min_tens, min_ones, sec_tens, sec_ones}, 4 bits each
- start  input  1  1-cycle strobe: begin/resume counting
- pause  input  1  1-cycle strobe: suspend counting
- clear  input  1  1-cycle strobe: abort to IDLE, value zeroed
- timer_en  output  1  enable to the tick generator; high only in RUN
- digits  output  16  current BCD value, same packing as `load_val`
- running  output  1  high in RUN
- expired  output  1  1-cycle pulse when the count reaches 00:00
- load_err  output  1  1-cycle pulse when a load is rejected

Behaviour:
- Reset (`rst`=0 at posedge): state IDLE; `digits`=16'h0000. `timer_en`, `running`, `expired`, `load_err` all 0. Internal tick-edge register cleared.
- States and transitions:
  - IDLE: `load` → LOADED.
  - LOADED: `start` → RUN. `start` ignored if `digits`==0000. `load` re-captures.
  - RUN: tick decrements the value. `pause` → PAUSE. Reaching 0000 → DONE. `load` ignored, no error.
  - PAUSE: `start` → RUN. `load` → LOADED.
  - DONE: `load` → LOADED. `start` ignored.
  - Any state, `clear` → IDLE with `digits`=0000.
- Priority within one cycle: `clear` > `pause` > `start` > `load`.
- `tick` arriving in the same cycle as `pause` is applied, then the block enters PAUSE.
- Load validation:
  - Legal: every nibble ≤9, `sec_tens` ≤5, `min_tens` ≤ MIN_TENS_MAX.
  - Illegal: `load_err`=1 for one cycle; `digits` and state unchanged.
  - Legal load of 0000 enters LOADED but `start` is ignored.
- Decrement (BCD borrow chain):
  - `sec_ones` 0 → 9 with borrow, `sec_tens` 0 → 5 with borrow, `min_ones` 0 → 9 with borrow, `min_tens` decrements.
  - Example: 10:00 → 09:59; 01:00 → 00:59.
- Latency: qualified tick sampled at posedge N; `digits` shows the new value after posedge N.
- Expiry:
  - The tick that makes `digits`=0000 sets `expired`=1 in that same registered update and moves the state to DONE.
  - `timer_en` and `running` are 0 from the same edge.
  - `expired` returns to 0 on the next edge.
- `timer_en` is 0 in every state except RUN. The generator clears its own count when `timer_en` falls, so each resume restarts a full second.
- `tick` is ignored whenever the state is not RUN.
- With TICK_WIDTH_CHECK=1, a tick counts only when `tick`=1 and the previous-cycle `tick`=0.
- Reset mid-count: everything returns to reset values regardless of state.

Optional Feature:
- Macro `COUNTDOWN_AUTO_RELOAD_EN`.
- Defined:
  - The last legal loaded value is stored in a shadow register.
  - On expiry the block still pulses `expired`, but it reloads `digits` from the shadow and stays in RUN; `timer_en` remains 1.
  - `clear` also zeroes the shadow.
  - A shadow of 0000 behaves as not defined.
- Not defined: no shadow register; expiry always enters DONE as above.

Test Plan:
- Reset, then load 16'h0003, start, apply 3 ticks 5 cycles apart → `digits` 0002, 0001, 0000; `expired` pulses once with `digits`=0000; `timer_en`=0 from that edge; state DONE.
- Load 16'h1000, start, 1 tick → `digits`=16'h0959. Load 16'h0100 + tick → 16'h0059.
- Load 16'h0070 (`sec_tens`=7) → `load_err` 1 cycle, `digits` unchanged, state unchanged. Load 16'hA000 → same.
- Load 0005, start, 2 ticks, `pause` with a simultaneous tick → `digits`=0002, `timer_en`=0. Further ticks ignored. `start` → RUN, next tick → 0001.
- `tick` held high 4 cycles with TICK_WIDTH_CHECK=1 → single decrement. With TICK_WIDTH_CHECK=0 → 4 decrements.
- Mid-RUN at 0042, assert `rst`=0 one cycle → all outputs 0, IDLE. With `COUNTDOWN_AUTO_RELOAD_EN`: load 0002, run 2 ticks → `expired` pulse, `digits`=0002, `running`=1.
